// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared packing-mode and FSM state types for the stream packer
package stream_pkg;

  typedef enum logic [1:0] {
    MODE_CONCAT    = 2'd0,
    MODE_REVERSE   = 2'd1,
    MODE_REPLICATE = 2'd2,
    MODE_RSVD      = 2'd3
  } pack_mode_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

endpackage

// File: rtl/packer_slot_reg.sv
// rtl/packer_slot_reg.sv - N x W field slot register file with indexed write, flat read-out
module packer_slot_reg #(
  parameter int W     = 2,
  parameter int N     = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [W-1:0]     wdata_i,
  output logic [N*W-1:0]   slots_o
);

  logic [N*W-1:0] slots_q;
  logic [N*W-1:0] slots_d;

  always_comb begin
    slots_d = slots_q;
    for (int i = 0; i < N; i++) begin
      if (we_i && (idx_i == IDX_W'(i))) begin
        slots_d[i*W +: W] = wdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q <= '0;
    end else begin
      slots_q <= slots_d;
    end
  end

  assign slots_o = slots_q;

endmodule

// File: rtl/stream_concat_packer.sv
// rtl/stream_concat_packer.sv - collects N W-bit beats into one registered packed word
// STREAM_CONCAT_PACKER_REPLICATE_EN builds mode 2 replication; otherwise mode 2 is reserved.
module stream_concat_packer #(
  parameter int W   = 2,
  parameter int N   = 5,
  parameter int REP = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*W*REP-1:0] out_data,
  output logic               mode_err
);
  import stream_pkg::*;

  localparam int CW = $clog2(N);
  localparam int BW = N * W;
  localparam int OW = N * W * REP;

  pack_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q;
  pack_mode_t       mode_q;
  logic [OW-1:0]    out_data_q;
  logic             mode_err_q;
  logic             accept;
  logic             last_beat;
  logic [BW-1:0]    slots;
  logic [BW-1:0]    slots_all;
  logic [BW-1:0]    base_fwd;
  logic [OW-1:0]    packed_d;

  function automatic logic is_rsvd(input pack_mode_t m);
`ifdef STREAM_CONCAT_PACKER_REPLICATE_EN
    return m == MODE_RSVD;
`else
    return (m == MODE_RSVD) || (m == MODE_REPLICATE);
`endif
  endfunction

  packer_slot_reg #(.W(W), .N(N), .IDX_W(CW)) u_slots (
    .clk     (clk),
    .rst     (rst),
    .we_i    (accept),
    .idx_i   (cnt_q),
    .wdata_i (in_data),
    .slots_o (slots)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            last_beat = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // The last beat is not in the slot file yet, so merge it in before packing.
  always_comb begin
    slots_all = slots;
    slots_all[(N-1)*W +: W] = in_data;
    base_fwd = '0;
    for (int i = 0; i < N; i++) begin
      base_fwd[(N-1-i)*W +: W] = slots_all[i*W +: W];
    end
    packed_d = '0;
    case (mode_q)
      MODE_REVERSE: packed_d[BW-1:0] = slots_all;
`ifdef STREAM_CONCAT_PACKER_REPLICATE_EN
      MODE_REPLICATE: begin
        for (int r = 0; r < REP; r++) begin
          packed_d[r*BW +: BW] = base_fwd;
        end
      end
`endif
      default: packed_d[BW-1:0] = base_fwd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      mode_q     <= MODE_CONCAT;
      out_data_q <= '0;
      mode_err_q <= 1'b0;
    end else begin
      mode_err_q <= 1'b0;
      if (accept) begin
        if (cnt_q == '0) begin
          mode_q     <= pack_mode_t'(in_mode);
          mode_err_q <= is_rsvd(pack_mode_t'(in_mode));
        end
        if (last_beat) begin
          cnt_q      <= '0;
          out_data_q <= packed_d;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign out_data = out_data_q;
  assign mode_err = mode_err_q;

endmodule
